groestl_arc_stage: RTL and testbench
====================================

Name: groestl_arc_stage

Overview:
- Registered AddRoundConstant stage for the Groestl-256 P/Q permutations, on the 512-bit (8x8 byte) state.
- Sits directly upstream of the combinational SubBytes array. Its registered output feeds the 64 S-box inputs.
- Applies the P or Q round constant for a given round number.
- Decouples the round datapath with a valid/ready handshake and optional skid buffering.

Parameters:
- ROUNDS, 10: number of permutation rounds. Legal in_round values are 0..ROUNDS-1.
- RW, 4: width of the round-number field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents a state.
- in_ready  out  1  stage can accept this cycle.
- in_state  in  512  state bytes, column-major. Byte k = 8*col+row sits at bits [511-8k : 504-8k].
- in_q  in  1  0 = permutation P, 1 = permutation Q.
- in_round  in  RW  round index i.
- in_last  in  1  sideband marker, passed through unchanged.
- out_valid  out  1  registered result available.
- out_ready  in  1  downstream (SubBytes path) accepts.
- out_state  out  512  ARC(in_state), same byte layout; feeds the S-box inputs.
- out_q  out  1  registered copy of in_q.
- out_round  out  RW  registered copy of in_round.
- out_last  out  1  registered copy of in_last.
- out_err  out  1  registered flag: in_round >= ROUNDS.

Behaviour:
- Reset (async, active-high): out_valid=0, out_state=0, out_q=0, out_round=0, out_last=0, out_err=0, skid buffer empty.
  - in_ready=1 as soon as rst deasserts.
  - An in-flight item is discarded when reset asserts mid-operation.
- Transfer rules:
  - Input transfer happens when in_valid & in_ready.
  - Output transfer happens when out_valid & out_ready.
  - Latency is 1 cycle: input accepted at edge N appears on out_* after edge N.
- Constant for P:
  - Row-0 byte of column j is XORed with {j[2:0],1'b0} << 3 ^ i, i.e. (j<<4) ^ i.
  - All other bytes pass unchanged.
- Constant for Q:
  - Every byte is XORed with 0xFF.
  - Additionally, the row-7 byte of column j is XORed with (j<<4) ^ i.
- Width of the constant: i is zero-extended to 8 bits.
  - RW <= 4 is required, so (j<<4) and i never overlap.
- out_state holds stable while out_valid & ~out_ready.
- Round error: in_round >= ROUNDS sets out_err for that item.
  - The constant is still computed from in_round as given.
  - The item is not dropped. Flagging is the only action.
- Throughput and ready:
  - One item per cycle with macro enabled.
  - Without the macro: one item per cycle while out_ready=1, and a bubble-free stall.
- Simultaneous accept and drain in the same cycle: the output register reloads. out_valid stays 1.
- Backpressure never loses or duplicates an item. Order is strictly FIFO.

Optional Feature:
- Macro: GROESTL_ARC_SKID_EN.
- Defined:
  - A 2-entry skid buffer (output register + spill register) is used.
  - in_ready is driven purely from flops: in_ready = spill register empty. There is no combinational path from out_ready.
  - When out_ready drops, one extra item is absorbed into the spill register.
  - On the next out_ready, the spill register drains before new input.
- Undefined:
  - A single output register is used.
  - in_ready = ~out_valid | out_ready (combinational).
  - Functional results are identical; only ready timing differs.

Decomposition:
- Shared package groestl_pkg holds:
  - GROESTL_STATE_W=512, GROESTL_COLS=8, GROESTL_ROWS=8, GROESTL256_ROUNDS=10.
  - The byte-index helper (col,row -> bit offset).
  - The P/Q select encoding.
- One sub-module is natural: groestl_arc_const. It is the combinational constant XOR (state, q, round) -> state, reusable by the Groestl-512 variant.
- groestl_arc_stage wraps groestl_arc_const with the handshake/skid registers.

Test Plan:
- P, round 0, all-zero state, out_ready=1 → one cycle later:
  - bytes 0,8,16,...,56 = 0x00,0x10,0x20,...,0x70;
  - all other bytes 0x00; out_err=0.
- Q, round 3, all-zero state → all bytes 0xFF except the row-7 bytes: byte7=0xFC, byte15=0xEC, byte63=0x8C; out_q=1, out_round=3.
- Stream of 10 P items, rounds 0..9, with out_ready held 0 for 3 cycles mid-stream → all 10 emerge in order, none lost or duplicated.
  - Macro on: in_ready deasserts exactly one accept after out_ready drops.
- in_round=10 with in_last=1 → out_err=1, out_last=1, constant applied with i=0xA (P: byte0 = 0x0A on zero state).
- Assert rst while out_valid=1 and stalled → out_valid=0 immediately (async), outputs zero. After release, in_ready=1 and the next item processes normally.
- Back-to-back accept and drain every cycle for 20 items → out_valid stays 1 throughout, one output per cycle.

Source files
------------

// File: rtl/groestl_pkg.sv
// groestl_pkg: shared Groestl geometry, P/Q select encoding and state byte addressing.
package groestl_pkg;
  localparam int GROESTL_STATE_W = 512;
  localparam int GROESTL_COLS = 8;
  localparam int GROESTL_ROWS = 8;
  localparam int GROESTL256_ROUNDS = 10;
  localparam int ARC_ROW_P = 0;
  localparam int ARC_ROW_Q = 7;
  typedef enum logic {PERM_P = 1'b0, PERM_Q = 1'b1} perm_e;
  // Byte k = 8*col+row is stored most-significant first.
  function automatic int byte_lsb(input int col, input int row);
    return GROESTL_STATE_W - 8 - 8 * (GROESTL_ROWS * col + row);
  endfunction
endpackage

// File: rtl/groestl_arc_const.sv
// groestl_arc_const: combinational Groestl AddRoundConstant for P or Q on a 512-bit state.
module groestl_arc_const
  import groestl_pkg::*;
#(
  parameter int RW = 4
) (
  input  logic [GROESTL_STATE_W-1:0] st,
  input  logic                       q,
  input  logic [RW-1:0]              round,
  output logic [GROESTL_STATE_W-1:0] res
);
  always_comb begin
    res = (q == PERM_Q) ? ~st : st;
    for (int j = 0; j < GROESTL_COLS; j++)
      res[byte_lsb(j, (q == PERM_Q) ? ARC_ROW_Q : ARC_ROW_P) +: 8] ^= 8'(j << 4) ^ 8'(round);
  end
endmodule

// File: rtl/groestl_arc_stage.sv
// groestl_arc_stage: registered AddRoundConstant stage with valid/ready handshake.
// GROESTL_ARC_SKID_EN adds a spill register so in_ready comes only from flops.
module groestl_arc_stage
  import groestl_pkg::*;
#(
  parameter int ROUNDS = GROESTL256_ROUNDS,
  parameter int RW = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [GROESTL_STATE_W-1:0] in_state,
  input  logic                       in_q,
  input  logic [RW-1:0]              in_round,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [GROESTL_STATE_W-1:0] out_state,
  output logic                       out_q,
  output logic [RW-1:0]              out_round,
  output logic                       out_last,
  output logic                       out_err
);
  localparam int W = GROESTL_STATE_W + RW + 3;
  logic [GROESTL_STATE_W-1:0] arc;
  logic [W-1:0] nxt, out_r;
  logic take, drain;
  groestl_arc_const #(.RW(RW)) u_const (.st(in_state), .q(in_q), .round(in_round), .res(arc));
  assign nxt = {arc, in_q, in_round, in_last, 32'(in_round) >= ROUNDS};
  assign {out_state, out_q, out_round, out_last, out_err} = out_r;
  assign take = in_valid & in_ready;
  assign drain = out_valid & out_ready;
`ifdef GROESTL_ARC_SKID_EN
  logic sp_valid;
  logic [W-1:0] sp_r;
  assign in_ready = ~sp_valid;
  // The spill register is only ever occupied while the output register is full.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_r <= '0;
      sp_valid <= 1'b0;
      sp_r <= '0;
    end else if (drain | ~out_valid) begin
      if (sp_valid) begin
        out_r <= sp_r;
        sp_valid <= 1'b0;
      end else begin
        out_valid <= take;
        if (take) out_r <= nxt;
      end
    end else if (take) begin
      sp_r <= nxt;
      sp_valid <= 1'b1;
    end
`else
  assign in_ready = ~out_valid | out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_r <= '0;
    end else if (drain | ~out_valid) begin
      out_valid <= take;
      if (take) out_r <= nxt;
    end
`endif
endmodule

// File: tb/tb_groestl_arc_stage.sv
// tb_groestl_arc_stage: scoreboard bench for groestl_arc_stage (honours GROESTL_ARC_SKID_EN).
module tb_groestl_arc_stage;
  localparam int W = 512 + 4 + 3;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_q = 0, in_last = 0;
  logic [511:0] in_state = '0, out_state;
  logic [3:0] in_round = '0, out_round;
  logic out_valid, out_ready = 1, out_q, out_last, out_err;
  logic [W-1:0] sb[$];
  int checks = 0, errors = 0;

  groestl_arc_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_q(in_q), .in_round(in_round), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .out_q(out_q), .out_round(out_round),
    .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string name);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] arc_model(input logic [511:0] s, input logic q, input logic [3:0] r);
    logic [511:0] o;
    logic [7:0] b;
    int col, row;
    o = s;
    for (int k = 0; k < 64; k++) begin
      b = s[511-8*k -: 8];
      col = k / 8;
      row = k % 8;
      if (q) b = ~b;
      if (row == (q ? 7 : 0)) b = b ^ {col[2:0], 4'h0} ^ {4'h0, r};
      o[511-8*k -: 8] = b;
    end
    return o;
  endfunction

  // Called at a falling edge; returns at a falling edge after the item is accepted.
  task automatic send(input logic [511:0] s, input logic q, input logic [3:0] r, input logic l,
                      input logic [511:0] e, input logic err);
    logic ok;
    ok = 0;
    in_state = s; in_q = q; in_round = r; in_last = l; in_valid = 1;
    for (int t = 0; t < 200 && !ok; t++) begin
      #1;
      ok = in_ready;
      if (ok) sb.push_back({e, q, r, l, err});
      @(negedge clk);
    end
    in_valid = 0;
    if (!ok) chk(0, 1, "accept_timeout");
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e, g;
    #3;
    if (!rst && out_valid && out_ready) begin
      g = {out_state, out_q, out_round, out_last, out_err};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", g);
      end else begin
        e = sb.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL output: got %0h expected %0h", g, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] s;
    #1;
    chk({31'b0, out_valid}, 0, "reset_valid");
    chk({31'b0, |out_state}, 0, "reset_state");
    chk({27'b0, out_q, out_round, out_last, out_err}, 0, "reset_side");
    repeat (2) @(negedge clk);
    rst = 0;
    #1 chk({31'b0, in_ready}, 1, "ready_after_reset");
    @(negedge clk);
    send('0, 0, 4'd0, 0, {8{8'h70, 56'h0}} & '0 | {64'h00 << 56, 64'h10 << 56, 64'h20 << 56,
         64'h30 << 56, 64'h40 << 56, 64'h50 << 56, 64'h60 << 56, 64'h70 << 56}, 0);
    send('0, 1, 4'd3, 0, {64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFEC, 64'hFFFFFFFFFFFFFFDC,
         64'hFFFFFFFFFFFFFFCC, 64'hFFFFFFFFFFFFFFBC, 64'hFFFFFFFFFFFFFFAC, 64'hFFFFFFFFFFFFFF9C,
         64'hFFFFFFFFFFFFFF8C}, 0);
    send('0, 0, 4'd10, 1, {64'h0A << 56, 64'h1A << 56, 64'h2A << 56, 64'h3A << 56,
         64'h4A << 56, 64'h5A << 56, 64'h6A << 56, 64'h7A << 56}, 1);
    send({16{32'h0123ABCD}}, 1, 4'd15, 0, {8{64'hFEDC5432FEDC5432}} ^
         {64'h0, 64'h10, 64'h20, 64'h30, 64'h40, 64'h50, 64'h60, 64'h70} ^ {8{64'h0F}}, 1);
    repeat (3) @(negedge clk);
    fork
      for (int k = 0; k < 10; k++) begin
        s = {16{32'hA5000000 | k}};
        send(s, 0, 4'(k), k == 9, arc_model(s, 0, 4'(k)), 0);
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 0;
`ifdef GROESTL_ARC_SKID_EN
        #2 chk({31'b0, in_ready}, 1, "ready_at_stall");
        @(negedge clk);
        #2 chk({31'b0, in_ready}, 0, "ready_after_absorb");
`else
        #2 chk({31'b0, in_ready}, 0, "ready_at_stall");
        @(negedge clk);
`endif
        repeat (2) @(negedge clk);
        out_ready = 1;
      end
    join
    repeat (4) @(negedge clk);
    chk(sb.size(), 0, "stream_drained");
    out_ready = 0;
    send({64{8'h3C}}, 1, 4'd5, 1, arc_model({64{8'h3C}}, 1, 4'd5), 0);
    #1 chk({31'b0, out_valid}, 1, "stalled_valid");
    #1 rst = 1;
    #1 chk({31'b0, out_valid}, 0, "async_reset_valid");
    chk({27'b0, out_q, out_round, out_last, out_err, |out_state}, 0, "async_reset_outputs");
    sb.delete();
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    #1 chk({31'b0, in_ready}, 1, "ready_after_rst");
    @(negedge clk);
    send('0, 0, 4'd2, 0, arc_model('0, 0, 4'd2), 0);
    repeat (3) @(negedge clk);
    fork
      for (int k = 0; k < 20; k++) begin
        s = {8{64'h0011223344556677 + 64'(k)}};
        send(s, k[0], 4'(k % 10), k == 19, arc_model(s, k[0], 4'(k % 10)), 0);
      end
      begin
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
          #3 chk({31'b0, out_valid}, 1, "b2b_valid");
          @(negedge clk);
        end
      end
    join
    repeat (5) @(negedge clk);
    chk(sb.size(), 0, "final_drained");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
